// File: rtl/spiflash_responder.sv
// SPI NOR flash slave model: oversampled mode-0 SPI, serves READ/FAST_READ
// from a byte-wide BRAM port, plus JEDEC ID and status commands.
module spiflash_responder #(
  parameter int          ADDR_W     = 24,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
  parameter logic [7:0]  STATUS_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rd_data,
  output logic              busy,
  output logic [7:0]        last_cmd
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, DATA, JEDEC, STATUS, IGNORE
  } state_t;

  logic [1:0] sck_s, cs_s, mosi_s;
  logic       sck_d, cs_d;

  // Sync flops reset low so a CS_N already low at release never looks
  // like a falling edge; a full high/low cycle is needed to start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_s  <= '0;
      cs_s   <= '0;
      mosi_s <= '0;
      sck_d  <= 1'b0;
      cs_d   <= 1'b0;
    end else begin
      sck_s  <= {sck_s[0], spi_sck};
      cs_s   <= {cs_s[0], spi_cs_n};
      mosi_s <= {mosi_s[0], spi_mosi};
      sck_d  <= sck_s[1];
      cs_d   <= cs_s[1];
    end
  end

  logic sck_rise, sck_fall, cs_hi, cs_fall;

  assign sck_rise = sck_s[1] & ~sck_d;
  assign sck_fall = ~sck_s[1] & sck_d;
  assign cs_hi    = cs_s[1];
  assign cs_fall  = ~cs_s[1] & cs_d;

  state_t            state_q, state_n;
  logic [4:0]        bit_cnt_q, bit_cnt_n;
  logic [23:0]       sh_q, sh_n, sh_in;
  logic              fast_q, fast_n;
  logic [7:0]        tx_q, tx_n;
  logic [2:0]        tx_left_q, tx_left_n;
  logic [1:0]        id_idx_q, id_idx_n;
  logic [7:0]        buf_q, buf_n;
  logic              rd_q;
  logic              miso_q, miso_n;
  logic              oe_q;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              rd_en_q, rd_en_n;
  logic [7:0]        last_cmd_q, last_cmd_n;
  logic              ld;
  logic [7:0]        ld_byte;

  assign sh_in = {sh_q[22:0], mosi_s[1]};

  always_comb begin
    state_n    = state_q;
    bit_cnt_n  = bit_cnt_q;
    sh_n       = sh_q;
    fast_n     = fast_q;
    tx_n       = tx_q;
    tx_left_n  = tx_left_q;
    id_idx_n   = id_idx_q;
    miso_n     = miso_q;
    addr_n     = addr_q;
    rd_en_n    = 1'b0;
    last_cmd_n = last_cmd_q;
    buf_n      = rd_q ? mem_rd_data : buf_q;
    ld         = 1'b0;
    ld_byte    = '0;
    if (cs_hi) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      tx_left_n = '0;
      id_idx_n  = '0;
      fast_n    = 1'b0;
      miso_n    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (cs_fall) begin
          state_n   = CMD;
          bit_cnt_n = '0;
          tx_left_n = '0;
        end
        CMD: if (sck_rise) begin
          sh_n      = sh_in;
          bit_cnt_n = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            last_cmd_n = sh_in[7:0];
            bit_cnt_n  = '0;
            fast_n     = (sh_in[7:0] == 8'h0B);
            case (sh_in[7:0])
              8'h03, 8'h0B: state_n = ADDR;
              8'h9F:        state_n = JEDEC;
              8'h05:        state_n = STATUS;
              default:      state_n = IGNORE;
            endcase
          end
        end
        ADDR: if (sck_rise) begin
          sh_n      = sh_in;
          bit_cnt_n = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            addr_n    = sh_in[ADDR_W-1:0];
            rd_en_n   = 1'b1;
            bit_cnt_n = '0;
            state_n   = fast_q ? DUMMY : DATA;
          end
        end
        DUMMY: if (sck_rise) begin
          bit_cnt_n = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_n = '0;
            state_n   = DATA;
          end
        end
        DATA: if (sck_fall && tx_left_q == 3'd0) begin
          // Consume the prefetched byte and fetch the following one.
          ld      = 1'b1;
          ld_byte = buf_q;
          addr_n  = addr_q + ADDR_W'(1);
          rd_en_n = 1'b1;
        end
        JEDEC: if (sck_fall && tx_left_q == 3'd0) begin
          ld = 1'b1;
          case (id_idx_q)
            2'd0:    ld_byte = JEDEC_ID[23:16];
            2'd1:    ld_byte = JEDEC_ID[15:8];
            2'd2:    ld_byte = JEDEC_ID[7:0];
            default: ld_byte = 8'h00;
          endcase
          if (id_idx_q != 2'd3) id_idx_n = id_idx_q + 2'd1;
        end
        STATUS: if (sck_fall && tx_left_q == 3'd0) begin
          ld      = 1'b1;
          ld_byte = STATUS_VAL;
        end
        IGNORE: ;
      endcase
      if (sck_fall && (state_q == DATA || state_q == JEDEC ||
                       state_q == STATUS)) begin
        if (ld) begin
          miso_n    = ld_byte[7];
          tx_n      = {ld_byte[6:0], 1'b0};
          tx_left_n = 3'd7;
        end else begin
          miso_n    = tx_q[7];
          tx_n      = {tx_q[6:0], 1'b0};
          tx_left_n = tx_left_q - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      fast_q     <= 1'b0;
      tx_q       <= '0;
      tx_left_q  <= '0;
      id_idx_q   <= '0;
      buf_q      <= '0;
      rd_q       <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      last_cmd_q <= '0;
    end else begin
      state_q    <= state_n;
      bit_cnt_q  <= bit_cnt_n;
      sh_q       <= sh_n;
      fast_q     <= fast_n;
      tx_q       <= tx_n;
      tx_left_q  <= tx_left_n;
      id_idx_q   <= id_idx_n;
      buf_q      <= buf_n;
      rd_q       <= rd_en_q;
      miso_q     <= miso_n;
      oe_q       <= ~cs_s[1];
      addr_q     <= addr_n;
      rd_en_q    <= rd_en_n;
      last_cmd_q <= last_cmd_n;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign busy        = oe_q;
  assign mem_addr    = addr_q;
  assign mem_rd_en   = rd_en_q;
  assign last_cmd    = last_cmd_q;

endmodule

// File: tb/tb_spiflash_responder.sv
// Directed bench for spiflash_responder (ADDR_W=8) with a BRAM model
// and a bit-banged mode-0 SPI master running at clk/8.
module tb_spiflash_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_sck, spi_cs_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rd_data = 8'h00;
  logic       busy;
  logic [7:0] last_cmd;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [256];
  logic [7:0] addr_log [$];

  always #5 clk = ~clk;

  spiflash_responder #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data),
    .busy(busy), .last_cmd(last_cmd)
  );

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_addr];
      addr_log.push_back(mem_addr);
    end
  end

  task automatic xfer(input logic [7:0] tx, input int n,
                      output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      spi_sck  = 1'b0;
      spi_mosi = tx[7-i];
      repeat (4) @(negedge clk);
      rx = {rx[6:0], spi_miso};
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic cs_on();
    @(negedge clk);
    spi_sck  = 1'b0;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_off();
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] d;
    xfer(op, 8, d);
    xfer(a[23:16], 8, d);
    xfer(a[15:8], 8, d);
    xfer(a[7:0], 8, d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({spi_miso, spi_miso_oe, busy, mem_rd_en} !== 4'b0) begin
      $display("FAIL reset_ctl: got %b expected 0000",
               {spi_miso, spi_miso_oe, busy, mem_rd_en});
      fails++;
    end
    tests++;
    if (mem_addr !== 8'h00) begin
      $display("FAIL reset_addr: got %h expected 00", mem_addr);
      fails++;
    end
    tests++;
    if (last_cmd !== 8'h00) begin
      $display("FAIL reset_cmd: got %h expected 00", last_cmd);
      fails++;
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      $display("FAIL idle_busy: got %b expected 0", busy);
      fails++;
    end
  endtask

  task automatic test_basic_read();
    logic [7:0] r0, r1;
    int base;
    base = addr_log.size();
    cs_on();
    tests++;
    if (busy !== 1'b1 || spi_miso_oe !== 1'b1) begin
      $display("FAIL busy_oe: got %b%b expected 11", busy, spi_miso_oe);
      fails++;
    end
    send_hdr(8'h03, 24'h000010);
    xfer(8'hFF, 8, r0);
    tests++;
    if (addr_log.size() - base != 2) begin
      $display("FAIL rd_pulses: got %0d expected 2",
               addr_log.size() - base);
      fails++;
    end
    xfer(8'hFF, 8, r1);
    tests++;
    if (r0 !== 8'hA5) begin
      $display("FAIL read_b0: got %h expected a5", r0);
      fails++;
    end
    tests++;
    if (r1 !== 8'h3C) begin
      $display("FAIL read_b1: got %h expected 3c", r1);
      fails++;
    end
    tests++;
    if (last_cmd !== 8'h03) begin
      $display("FAIL read_cmd: got %h expected 03", last_cmd);
      fails++;
    end
    cs_off();
  endtask

  task automatic test_fast_read();
    logic [7:0] d, r;
    cs_on();
    send_hdr(8'h0B, 24'h000010);
    xfer(8'h00, 8, d);
    xfer(8'h00, 8, r);
    cs_off();
    tests++;
    if (d !== 8'h00) begin
      $display("FAIL fast_dummy: got %h expected 00", d);
      fails++;
    end
    tests++;
    if (r !== 8'hA5) begin
      $display("FAIL fast_data: got %h expected a5", r);
      fails++;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] r0, r1;
    int base;
    base = addr_log.size();
    cs_on();
    send_hdr(8'h03, 24'h0000FF);
    xfer(8'h00, 8, r0);
    xfer(8'h00, 8, r1);
    cs_off();
    tests++;
    if ({r0, r1} !== 16'h1122) begin
      $display("FAIL wrap_data: got %h expected 1122", {r0, r1});
      fails++;
    end
    tests++;
    if (addr_log[base] !== 8'hFF || addr_log[base+1] !== 8'h00) begin
      $display("FAIL wrap_addr: got %h %h expected ff 00",
               addr_log[base], addr_log[base+1]);
      fails++;
    end
    cs_on();
    send_hdr(8'h03, 24'h123410);
    xfer(8'h00, 8, r0);
    cs_off();
    tests++;
    if (r0 !== 8'hA5) begin
      $display("FAIL trunc_addr: got %h expected a5", r0);
      fails++;
    end
  endtask

  task automatic test_ident_status();
    logic [7:0] d;
    logic [31:0] id;
    logic [15:0] st;
    cs_on();
    xfer(8'h9F, 8, d);
    for (int i = 0; i < 4; i++) begin
      xfer(8'h00, 8, d);
      id = {id[23:0], d};
    end
    cs_off();
    tests++;
    if (id !== 32'hEF401800) begin
      $display("FAIL jedec_id: got %h expected ef401800", id);
      fails++;
    end
    cs_on();
    xfer(8'h05, 8, d);
    xfer(8'h00, 8, st[15:8]);
    xfer(8'h00, 8, st[7:0]);
    cs_off();
    tests++;
    if (st !== 16'h0000) begin
      $display("FAIL status: got %h expected 0000", st);
      fails++;
    end
    tests++;
    if (last_cmd !== 8'h05) begin
      $display("FAIL status_cmd: got %h expected 05", last_cmd);
      fails++;
    end
  endtask

  task automatic test_abort_unknown();
    logic [7:0] d, r0, r1;
    int base;
    cs_on();
    xfer(8'h03, 8, d);
    xfer(8'h00, 8, d);
    xfer(8'hF0, 4, d);
    cs_off();
    cs_on();
    send_hdr(8'h03, 24'h000010);
    xfer(8'h00, 8, r0);
    cs_off();
    tests++;
    if (r0 !== 8'hA5) begin
      $display("FAIL abort_read: got %h expected a5", r0);
      fails++;
    end
    base = addr_log.size();
    cs_on();
    xfer(8'hAB, 8, d);
    tests++;
    if (last_cmd !== 8'hAB) begin
      $display("FAIL unk_cmd: got %h expected ab", last_cmd);
      fails++;
    end
    xfer(8'hFF, 8, r0);
    xfer(8'hFF, 8, r1);
    tests++;
    if ({r0, r1} !== 16'h0000) begin
      $display("FAIL unk_miso: got %h expected 0000", {r0, r1});
      fails++;
    end
    tests++;
    if (spi_miso_oe !== 1'b1) begin
      $display("FAIL unk_oe: got %b expected 1", spi_miso_oe);
      fails++;
    end
    cs_off();
    tests++;
    if (addr_log.size() != base) begin
      $display("FAIL unk_rd: got %0d expected 0", addr_log.size() - base);
      fails++;
    end
  endtask

  task automatic test_reset_mid_data();
    logic [7:0] d, r0, r1;
    int base;
    cs_on();
    send_hdr(8'h03, 24'h000010);
    xfer(8'h00, 8, d);
    xfer(8'h00, 4, d);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if ({spi_miso, spi_miso_oe, busy, mem_rd_en, mem_addr, last_cmd}
        !== 20'h0) begin
      $display("FAIL mid_reset: got %h expected 00000",
               {spi_miso, spi_miso_oe, busy, mem_rd_en, mem_addr, last_cmd});
      fails++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    base = addr_log.size();
    xfer(8'h03, 8, r0);
    xfer(8'hFF, 8, r1);
    tests++;
    if ({r0, r1} !== 16'h0000 || addr_log.size() != base) begin
      $display("FAIL post_reset_quiet: got %h/%0d expected 0000/0",
               {r0, r1}, addr_log.size() - base);
      fails++;
    end
    cs_off();
    cs_on();
    send_hdr(8'h03, 24'h000011);
    xfer(8'h00, 8, r0);
    cs_off();
    tests++;
    if (r0 !== 8'h3C) begin
      $display("FAIL post_reset_read: got %h expected 3c", r0);
      fails++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h11] = 8'h3C;
    mem[8'hFF] = 8'h11;
    mem[8'h00] = 8'h22;
    test_reset();
    test_basic_read();
    test_fast_read();
    test_wrap();
    test_ident_status();
    test_abort_unknown();
    test_reset_mid_data();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
